c_wait_merge_n: RTL
===================

Name: c_wait_merge_n

Overview:
- Clocked, parametrised successor of the two-channel drive/free wait-merge (join) control element.
- Accepts tokens on NCH input channels, each with a DW-bit payload, into per-channel buffers of depth DEPTH.
- When every enabled channel holds a token, emits one merged token carrying the concatenated heads. It then holds that token until the consumer frees it.
- Adds what the two-channel element lacks: input buffering, a runtime channel mask, per-channel credit return and error detection.

Parameters:
- NCH, 2, number of input channels (>=2).
- DW, 1, payload width per channel (>=1).
- DEPTH, 2, tokens buffered per channel (power of two, >=1).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_drive  input  NCH  one-cycle pulse per token on channel i.
- i_data  input  NCH*DW  channel i payload in bits [i*DW +: DW], sampled with i_drive[i].
- o_free  output  NCH  one-cycle credit-return pulse per consumed token of channel i.
- i_chanMask  input  NCH  1 = channel i enabled (waited on), 0 = ignored.
- o_driveNext  output  1  one-cycle pulse: merged token valid.
- o_data  output  NCH*DW  merged payload; masked channels read zero.
- i_freeNext  input  1  one-cycle pulse: consumer has taken the merged token.
- o_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous on rst high, released synchronously): all counts and pointers 0, FSM IDLE, o_driveNext=0, o_free=0, o_data=0, o_err=0.
- Reset mid-WAIT discards all buffered and outstanding tokens; no o_free pulse is issued for them.
- Push: i_drive[i] high at edge k writes i_data slice into FIFO i and increments count[i].
  - Push while count[i]==DEPTH: token dropped, count unchanged, o_err set.
  - Senders are credit-limited to DEPTH outstanding tokens; each o_free pulse returns one credit.
- FSM IDLE:
  - Join condition = at least one enabled channel, and count[i]>0 for every enabled channel.
  - When the join condition holds, at the next edge: latch o_data (FIFO heads, zeros for masked channels), latch the active mask, pulse o_driveNext for exactly one cycle, go to WAIT.
  - Latency: last required i_drive high in cycle k gives o_driveNext high in cycle k+2.
- FSM WAIT:
  - o_data and the latched mask are held stable; i_chanMask changes are ignored until return to IDLE.
  - On i_freeNext: pop the head of every latched-enabled FIFO, pulse o_free[i] for those channels in the next cycle, return to IDLE.
  - i_freeNext is legal in the same cycle o_driveNext is high.
  - The next o_driveNext may occur at the earliest 2 cycles after the i_freeNext cycle.
- i_freeNext while IDLE: ignored, o_err set.
- Push and pop on the same channel in the same cycle: both performed, count unchanged.
  - Pop uses the pre-push head.
  - A push to a full FIFO coinciding with a pop is accepted; this is not an error.
- All channels masked: the join never fires and no error is raised.
- Pointers wrap modulo DEPTH; count range is 0..DEPTH, width clog2(DEPTH+1).
- o_err clears only on rst.
- Masked channels still accept and buffer tokens and are never popped while masked.

Decomposition:
- Package cache_ctrl_pkg holds:
  - the merge FSM state enum {IDLE, WAIT};
  - a clog2 constant function;
  - the count-width helper.
- One sub-module, c_token_fifo, instantiated NCH times:
  - ports: push, push data, pop, head data, count, full, empty;
  - behaviour: async-reset FIFO with the simultaneous push/pop rule above.
- Top level owns the join logic, FSM, output registers, o_free generation and o_err.

Test Plan:
- Basic join (NCH=2, DW=1, mask=11):
  - Stimulus: i_drive[0] with data 1 in cycle 3, then i_drive[1] with data 0 in cycle 6.
  - Required: o_driveNext high in cycle 8 only, o_data=2'b01.
  - Then i_freeNext in cycle 10 gives o_free=2'b11 in cycle 11.
- Buffering (DEPTH=2):
  - Stimulus: two tokens on ch0 (data 1 then 0), one on ch1 (data 1).
  - Required: first merge o_data=2'b11.
  - After free, a third token on ch1 (data 0) gives second merge o_data=2'b00 two cycles later.
- Mask (NCH=4, DW=4, mask=0101):
  - Stimulus: tokens on ch0=4'hA, ch2=4'h3.
  - Required: o_data=16'h030A; o_free=0101 after free; ch1/ch3 counts unaffected.
- Overflow (DEPTH=2):
  - Stimulus: three pushes on ch0 with no merge.
  - Required: o_err=1 after the third push, count[0]=2.
  - A stray i_freeNext in IDLE also sets o_err.
- Simultaneous events:
  - Stimulus: i_freeNext coinciding with o_driveNext, with a push on full ch0 in the same cycle.
  - Required: pop and push both succeed, o_err stays 0, o_free pulses the next cycle.
- Reset mid-WAIT:
  - Stimulus: rst asserted asynchronously between edges while o_data=2'b11 is held.
  - Required: immediately o_data=0, o_driveNext=0, o_err=0; no o_free follows.
  - Fresh tokens after release merge normally.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types and width helpers for the wait-merge join
package cache_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } merge_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Count must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/c_token_fifo.sv
// rtl/c_token_fifo.sv - per-channel token buffer; a pop frees room for a same-cycle push
module c_token_fifo
   import cache_ctrl_pkg::*;
#(
   parameter int DW    = 1,
   parameter int DEPTH = 2,
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int            PW       = ptr_width(DEPTH);
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DW-1:0] mem [0:(1 << PW) - 1];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/c_wait_merge_n.sv
// rtl/c_wait_merge_n.sv - buffered N-channel join with channel mask, credit return and error flag
module c_wait_merge_n
   import cache_ctrl_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int DW    = 1,
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    i_drive,
   input  logic [NCH*DW-1:0] i_data,
   output logic [NCH-1:0]    o_free,
   input  logic [NCH-1:0]    i_chanMask,
   output logic              o_driveNext,
   output logic [NCH*DW-1:0] o_data,
   input  logic              i_freeNext,
   output logic              o_err
);

   localparam int CW = cnt_width(DEPTH);

   merge_state_t              state;
   merge_state_t              state_nxt;
   logic                      fire;
   logic [NCH-1:0]            mask_q;
   logic [NCH-1:0]            pop;
   logic [NCH-1:0]            full;
   logic [NCH-1:0]            empty;
   logic [NCH-1:0]            has_token;
   logic [NCH-1:0][CW-1:0]    cnt;
   logic [NCH*DW-1:0]         heads;
   logic [NCH*DW-1:0]         merged;
   logic                      join_ok;
   logic                      overflow;
   logic                      stray_free;

   assign pop = (state == WAIT && i_freeNext) ? mask_q : '0;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      c_token_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH),
         .CW    (CW)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (i_drive[g]),
         .push_data (i_data[g*DW +: DW]),
         .pop       (pop[g]),
         .head_data (heads[g*DW +: DW]),
         .count     (cnt[g]),
         .full      (full[g]),
         .empty     (empty[g])
      );
      assign has_token[g] = (cnt[g] != '0);
      // Gating on !empty keeps stale memory contents off the merged bus.
      assign merged[g*DW +: DW] = (i_chanMask[g] && !empty[g]) ? heads[g*DW +: DW] : '0;
   end

   assign join_ok    = (|i_chanMask) && (&(has_token | ~i_chanMask));
   assign overflow   = |(i_drive & full & ~pop);
   assign stray_free = (state == IDLE) && i_freeNext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            if (join_ok) begin
               fire      = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (i_freeNext) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_driveNext <= 1'b0;
         o_data      <= '0;
         mask_q      <= '0;
         o_free      <= '0;
         o_err       <= 1'b0;
      end else begin
         o_driveNext <= fire;
         o_free      <= pop;
         if (fire) begin
            o_data <= merged;
            mask_q <= i_chanMask;
         end
         if (overflow || stray_free) o_err <= 1'b1;
      end
   end

endmodule
